serial_subtractor: RTL and testbench

- Multi-cycle two's-complement subtractor: D = A − B − borrow_in.
- Processes one GROUP-bit chunk per cycle, LSB chunk first, through a single group-wide carry-lookahead stage, using A + ~B + ~borrow_in.
- Trades latency for area, complementing the combinational group adders in the arithmetic library.
- Operands enter and results leave through ready/valid handshakes.

---
 rtl/serial_subtractor.sv | 207 ++++++++++++++++++++
 tb/tb_serial_subtractor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle two's-complement subtractor, D = A - B - borrow_in.
// One GROUP-bit chunk per cycle, LSB chunk first, through a single group-wide
// carry-lookahead stage computing A + ~B + ~borrow_in.
//
// Ports:
//   clock         single clock for all state
//   reset         asynchronous, active-low reset
//   io_in_valid   operands valid
//   io_in_ready   block accepts operands (IDLE)
//   io_a / io_b   minuend / subtrahend (WIDTH bits)
//   io_b_in       borrow in
//   io_out_valid  result valid (DONE)
//   io_out_ready  consumer accepts result
//   io_d          difference (WIDTH bits)
//   io_b_out      borrow out, 1 when unsigned A < B + borrow_in
//   io_ovf        signed overflow
module serial_subtractor #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned GROUP = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_b_in,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_d,
  output logic             io_b_out,
  output logic             io_ovf
);

  localparam int unsigned NCHUNK = WIDTH / GROUP;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Lookahead carries for one group: c[i] = g[j] propagated through p[j+1..i-1],
  // or the incoming carry propagated through p[0..i-1].
  function automatic logic [GROUP:0] cla_carries(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             cin
  );
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= int'(GROUP); i++) begin
      term = cin;
      for (int j = 0; j < i; j++) begin
        term = term & p[j];
      end
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] nb_q,        nb_d;
  logic [WIDTH-1:0] res_q,       res_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             carry_q,     carry_d;
  logic             a_msb_q,     a_msb_d;
  logic             b_msb_q,     b_msb_d;
  logic [WIDTH-1:0] d_q,         d_d;
  logic             bout_q,      bout_d;
  logic             ovf_q,       ovf_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Current chunk always sits in the low GROUP bits of the operand shift registers.
  logic [GROUP-1:0] gen_c;
  logic [GROUP-1:0] prop_c;
  logic [GROUP:0]   carries_c;
  logic [GROUP-1:0] sum_c;
  logic [WIDTH-1:0] res_next_c;

  // One group-wide lookahead add step.
  always_comb begin
    gen_c      = a_q[GROUP-1:0] & nb_q[GROUP-1:0];
    prop_c     = a_q[GROUP-1:0] ^ nb_q[GROUP-1:0];
    carries_c  = cla_carries(gen_c, prop_c, carry_q);
    sum_c      = prop_c ^ carries_c[GROUP-1:0];
    // New chunk enters at the top so that after NCHUNK steps chunk k sits at slice k.
    res_next_c = (res_q >> GROUP) | (WIDTH'(sum_c) << (WIDTH - GROUP));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    nb_d        = nb_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    d_d         = d_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (io_in_valid && in_ready_q) begin
          a_d        = io_a;
          nb_d       = ~io_b;
          carry_d    = ~io_b_in;
          a_msb_d    = io_a[WIDTH-1];
          b_msb_d    = io_b[WIDTH-1];
          res_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end

      ST_BUSY: begin
        a_d     = a_q >> GROUP;
        nb_d    = nb_q >> GROUP;
        res_d   = res_next_c;
        carry_d = carries_c[GROUP];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CHUNK) begin
          cnt_d       = '0;
          d_d         = res_next_c;
          // Carry-out of A + ~B + ~bin is the inverse of the borrow.
          bout_d      = ~carries_c[GROUP];
          ovf_d       = (a_msb_q != b_msb_q) && (res_next_c[WIDTH-1] != a_msb_q);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (io_out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      d_q         <= d_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io_in_ready  = in_ready_q;
  assign io_out_valid = out_valid_q;
  assign io_d         = d_q;
  assign io_b_out     = bout_q;
  assign io_ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: transaction-level reference model plus directed
// literal cases from the test plan, then randomized handshake traffic.
module tb_serial_subtractor;

  localparam int unsigned W   = 12;
  localparam int unsigned G   = 3;
  localparam int          NCH = 4;

  logic         clock;
  logic         reset;
  logic         io_in_valid;
  logic         io_in_ready;
  logic [W-1:0] io_a;
  logic [W-1:0] io_b;
  logic         io_b_in;
  logic         io_out_valid;
  logic         io_out_ready;
  logic [W-1:0] io_d;
  logic         io_b_out;
  logic         io_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W), .GROUP(G)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_a         (io_a),
    .io_b         (io_b),
    .io_b_in      (io_b_in),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_d         (io_d),
    .io_b_out     (io_b_out),
    .io_ovf       (io_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: operation result from integer arithmetic, timing from
  // "valid NCH cycles after accept, held until consumed".
  int           m_left  = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] e_d     = '0;
  logic         e_bo    = 1'b0;
  logic         e_ovf   = 1'b0;

  always @(posedge clock or negedge reset) begin
    int ua, ub, sa, sb, bi, s;
    if (!reset) begin
      m_left  = 0;
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (io_out_ready) m_valid = 1'b0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) m_valid = 1'b1;
    end else if (io_in_valid) begin
      ua    = int'(io_a);
      ub    = int'(io_b);
      bi    = int'(io_b_in);
      sa    = (ua >= 2048) ? ua - 4096 : ua;
      sb    = (ub >= 2048) ? ub - 4096 : ub;
      s     = sa - sb - bi;
      e_d   = W'(ua - ub - bi);
      e_bo  = (ua < ub + bi);
      e_ovf = (s > 2047) || (s < -2048);
      m_left = NCH;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_valid", 32'(io_out_valid), 32'd0);
      chk("rst_d", 32'(io_d), 32'd0);
      chk("rst_bout", 32'(io_b_out), 32'd0);
      chk("rst_ovf", 32'(io_ovf), 32'd0);
    end else begin
      chk("in_ready", 32'(io_in_ready), 32'(!m_valid && m_left == 0));
      chk("out_valid", 32'(io_out_valid), 32'(m_valid));
      if (m_valid && io_out_valid) begin
        chk("d", 32'(io_d), 32'(e_d));
        chk("b_out", 32'(io_b_out), 32'(e_bo));
        chk("ovf", 32'(io_ovf), 32'(e_ovf));
      end
    end
  end

  // Directed operation with literal expectations, latency and backpressure hold.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input logic [W-1:0] xd, input logic xbo, input logic xovf,
                       input int hold, input string nm);
    int n;
    @(posedge clock); #1;
    io_a = a; io_b = b; io_b_in = bin; io_in_valid = 1'b1; io_out_ready = 1'b0;
    n = 0;
    @(negedge clock);
    while (!io_in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_accept"}, 32'(io_in_ready), 32'd1);
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    // Scramble inputs while busy; the captured operands must win.
    io_a = W'($urandom); io_b = W'($urandom); io_b_in = 1'($urandom);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!io_out_valid && n < 20);
    chk({nm, "_latency"}, 32'(n), 32'(NCH + 1));
    chk({nm, "_d"}, 32'(io_d), 32'(xd));
    chk({nm, "_bout"}, 32'(io_b_out), 32'(xbo));
    chk({nm, "_ovf"}, 32'(io_ovf), 32'(xovf));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({nm, "_hold_d"}, 32'(io_d), 32'(xd));
      chk({nm, "_hold_valid"}, 32'(io_out_valid), 32'd1);
      chk({nm, "_hold_ready"}, 32'(io_in_ready), 32'd0);
    end
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
    @(negedge clock);
    chk({nm, "_idle_ready"}, 32'(io_in_ready), 32'd1);
    chk({nm, "_idle_valid"}, 32'(io_out_valid), 32'd0);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    logic [W-1:0] v;
    case ($urandom % 8)
      0:       v = '0;
      1:       v = 12'hFFF;
      2:       v = 12'h800;
      3:       v = 12'h7FF;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    io_in_valid = 1'b0; io_out_ready = 1'b0;
    io_a = '0; io_b = '0; io_b_in = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("post_reset_ready", 32'(io_in_ready), 32'd1);

    do_op(12'h005, 12'h003, 1'b0, 12'h002, 1'b0, 1'b0, 0, "sub5_3");
    do_op(12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0, 0, "sub0_1");
    do_op(12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1, 0, "ovf_neg");
    do_op(12'h7FF, 12'hFFF, 1'b0, 12'h800, 1'b1, 1'b1, 0, "ovf_pos");
    do_op(12'h010, 12'h010, 1'b1, 12'hFFF, 1'b1, 1'b0, 0, "borrow_in");
    do_op(12'h123, 12'h0F0, 1'b0, 12'h033, 1'b0, 1'b0, 5, "backpress");

    // Abort during the second BUSY cycle.
    @(posedge clock); #1;
    io_a = 12'h123; io_b = 12'h045; io_b_in = 1'b0; io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("abort_d", 32'(io_d), 32'd0);
    chk("abort_valid", 32'(io_out_valid), 32'd0);
    chk("abort_bout", 32'(io_b_out), 32'd0);
    chk("abort_ovf", 32'(io_ovf), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("abort_no_valid", 32'(io_out_valid), 32'd0);
    end
    do_op(12'h00A, 12'h004, 1'b0, 12'h006, 1'b0, 1'b0, 0, "after_abort");

    // Back-to-back: both handshakes held high.
    @(posedge clock); #1;
    io_in_valid = 1'b1; io_out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      io_a = rand_opnd(); io_b = rand_opnd(); io_b_in = 1'($urandom);
      @(posedge clock); #1;
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      io_in_valid  = ($urandom % 3) != 0;
      io_out_ready = ($urandom % 3) == 0;
      io_a = rand_opnd(); io_b = rand_opnd(); io_b_in = 1'($urandom);
      @(posedge clock); #1;
    end
    io_in_valid = 1'b0; io_out_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
